// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared constants and controller state encoding for the I2C
//               master and its FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  localparam int I2C_DATA_WIDTH   = 8;
  localparam int FIFO_DEPTH       = 16;
  localparam int FIFO_ADDR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int FIFO_AFULL_LEVEL = 12;

  // Controller and FIFO-side logic share this encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_TX    = 2'd2,
    ST_RX    = 2'd3
  } i2c_state_e;

  function automatic int unsigned fifo_ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_tx_fifo_if
// Description : Host-side and controller-side signal bundle of the TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_tx_fifo_if
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = I2C_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);

  logic                  write;
  logic [DATA_WIDTH-1:0] data_wr;
  logic                  read;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   usedw;
  logic                  clear_err;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write, data_wr, read, clear_err,
    input  data_out, empty, full, almost_full, usedw, overflow, underflow
  );

  modport slave (
    input  write, data_wr, read, clear_err,
    output data_out, empty, full, almost_full, usedw, overflow, underflow
  );

endinterface
`default_nettype wire

// File: rtl/i2c_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : i2c_fifo_ram
// Description : Register-array RAM, one write port and one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_fifo_ram
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = I2C_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  input  wire logic                  wr_en_i,
  input  wire logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  wire logic [DATA_WIDTH-1:0] wr_data_i,
  input  wire logic                  rd_en_i,
  input  wire logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic      [DATA_WIDTH-1:0] rd_data_o
);

  localparam int c_WORDS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [c_WORDS];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage is intentionally not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read-before-write on an address collision returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/i2c_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : i2c_tx_fifo
// Description : Transmit FIFO between host writes and the I2C master controller.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_tx_fifo
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH  = I2C_DATA_WIDTH,
  parameter int DEPTH       = FIFO_DEPTH,
  parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int AFULL_LEVEL = FIFO_AFULL_LEVEL
) (
  input  wire logic    clk,
  input  wire logic    reset,
  i2c_tx_fifo_if.slave bus
);

  localparam logic [ADDR_WIDTH:0]   c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_AFULL = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0]   c_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_PINC  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   usedw_q,  usedw_d;
  logic                  empty_q,  empty_d;
  logic                  full_q,   full_d;
  logic                  afull_q,  afull_d;
  logic                  ovf_q,    ovf_d;
  logic                  unf_q,    unf_d;

  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // A pop frees a slot in the same edge, so a full FIFO can still take a write.
  assign w_wr_en = bus.write & (~full_q | bus.read);
  assign w_rd_en = bus.read & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (w_wr_en) begin
      wr_ptr_d = wr_ptr_q + c_PINC;
    end
    if (w_rd_en) begin
      rd_ptr_d = rd_ptr_q + c_PINC;
    end

    case ({w_wr_en, w_rd_en})
      2'b10:   usedw_d = usedw_q + c_ONE;
      2'b01:   usedw_d = usedw_q - c_ONE;
      default: usedw_d = usedw_q;
    endcase

    // Clear first so a coincident error event still sets the flag.
    if (bus.clear_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (bus.write & full_q & ~bus.read) begin
      ovf_d = 1'b1;
    end
    if (bus.read & empty_q) begin
      unf_d = 1'b1;
    end

    empty_d = (usedw_d == '0);
    full_d  = (usedw_d == c_DEPTH);
    afull_d = (usedw_d >= c_AFULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  i2c_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (w_wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.data_wr),
    .rd_en_i   (w_rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (w_rd_data)
  );

  assign bus.data_out    = w_rd_data;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.usedw       = usedw_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_tx_fifo
// Description : Self-checking bench for i2c_tx_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_tx_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  i2c_tx_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  i2c_tx_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .ADDR_WIDTH  (AW),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  bit            m_ovf;
  bit            m_unf;

  // Drive one cycle of stimulus and advance the reference model on the edge.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                      input bit clr, input bit rst);
    int  sz;
    bit  was_full, was_empty;
    bus.write = w; bus.data_wr = d; bus.read = r; bus.clear_err = clr; reset = rst;
    @(posedge clk);
    if (rst) begin
      q.delete(); m_dout = '0; m_ovf = 0; m_unf = 0;
    end else begin
      sz = q.size();
      was_full = (sz == DEPTH);
      was_empty = (sz == 0);
      if (r && !was_empty) m_dout = q.pop_front();
      if (w && (!was_full || r)) q.push_back(d);
      if (clr) begin m_ovf = 0; m_unf = 0; end
      if (w && was_full && !r) m_ovf = 1;
      if (r && was_empty) m_unf = 1;
    end
    #1;
    bus.write = 0; bus.read = 0; bus.clear_err = 0; reset = 0;
  endtask

  task automatic test_reset();
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", bus.almost_full); end
    checks++; if (bus.usedw !== 5'd0) begin errors++; $display("FAIL reset_usedw: got %0d want 0", bus.usedw); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", bus.data_out); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL reset_err: got ovf=%b unf=%b want 0 0", bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 8'(i + 1), 0, 0, 0);
      checks++;
      if (bus.usedw !== 5'(i + 1) || bus.almost_full !== (i + 1 >= AFULL)) begin
        errors++; $display("FAIL fill_level %0d: got usedw=%0d af=%b want %0d %b",
                           i, bus.usedw, bus.almost_full, i + 1, (i + 1 >= AFULL));
      end
    end
    checks++; if (bus.full !== 1'b1 || bus.empty !== 1'b0) begin
      errors++; $display("FAIL fill_full: got full=%b empty=%b want 1 0", bus.full, bus.empty);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, '0, 1, 0, 0);
      checks++;
      if (bus.data_out !== 8'(i + 1)) begin
        errors++; $display("FAIL drain_data %0d: got %h want %h", i, bus.data_out, 8'(i + 1));
      end
    end
    checks++; if (bus.empty !== 1'b1 || bus.usedw !== 5'd0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL drain_empty: got empty=%b usedw=%0d unf=%b want 1 0 0",
                         bus.empty, bus.usedw, bus.underflow);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom_range(0, 8'hA9)), 0, 0, 0);
    step(1, 8'hAA, 0, 0, 0);
    checks++; if (bus.overflow !== 1'b1 || bus.usedw !== 5'd16 || bus.full !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got ovf=%b usedw=%0d full=%b want 1 16 1",
                         bus.overflow, bus.usedw, bus.full);
    end
    step(1, 8'hAA, 0, 1, 0);
    checks++; if (bus.overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set_wins: got %b want 1", bus.overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, '0, 1, 0, 0);
      checks++;
      if (bus.data_out !== m_dout || bus.data_out === 8'hAA) begin
        errors++; $display("FAIL ovf_drain %0d: got %h want %h", i, bus.data_out, m_dout);
      end
    end
    step(0, '0, 0, 1, 0);
    checks++; if (bus.overflow !== 1'b0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL ovf_clear: got ovf=%b empty=%b want 0 1", bus.overflow, bus.empty);
    end
  endtask

  task automatic test_underflow_simul();
    step(1, 8'h5C, 1, 0, 0);
    checks++; if (bus.underflow !== 1'b1 || bus.usedw !== 5'd1 || bus.empty !== 1'b0) begin
      errors++; $display("FAIL unf_simul: got unf=%b usedw=%0d empty=%b want 1 1 0",
                         bus.underflow, bus.usedw, bus.empty);
    end
    step(0, '0, 1, 0, 0);
    checks++; if (bus.data_out !== 8'h5C || bus.empty !== 1'b1) begin
      errors++; $display("FAIL unf_read: got dout=%h empty=%b want 5c 1", bus.data_out, bus.empty);
    end
    step(0, '0, 1, 0, 0);
    checks++; if (bus.data_out !== 8'h5C || bus.usedw !== 5'd0) begin
      errors++; $display("FAIL unf_hold: got dout=%h usedw=%0d want 5c 0", bus.data_out, bus.usedw);
    end
    step(0, '0, 0, 1, 0);
    checks++; if (bus.underflow !== 1'b0) begin
      errors++; $display("FAIL unf_clear: got %b want 0", bus.underflow);
    end
  endtask

  task automatic test_full_wrap();
    int wr_k = 8'h30;
    int rd_k = 8'h30;
    for (int i = 0; i < DEPTH; i++) begin step(1, 8'(wr_k), 0, 0, 0); wr_k++; end
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(wr_k), 1, 0, 0); wr_k++;
      checks++;
      if (bus.usedw !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b0 ||
          bus.underflow !== 1'b0 || bus.data_out !== 8'(rd_k)) begin
        errors++; $display("FAIL wrap_simul %0d: got usedw=%0d full=%b ovf=%b unf=%b dout=%h want 16 1 0 0 %h",
                           i, bus.usedw, bus.full, bus.overflow, bus.underflow, bus.data_out, 8'(rd_k));
      end
      rd_k++;
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, '0, 1, 0, 0);
      checks++;
      if (bus.data_out !== 8'(rd_k)) begin
        errors++; $display("FAIL wrap_drain %0d: got %h want %h", i, bus.data_out, 8'(rd_k));
      end
      rd_k++;
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) step(1, 8'($urandom), 0, 0, 0);
    checks++; if (bus.usedw !== 5'd7) begin errors++; $display("FAIL rmid_pre: got %0d want 7", bus.usedw); end
    step(1, 8'h77, 0, 0, 1);
    checks++; if (bus.usedw !== 5'd0 || bus.empty !== 1'b1 || bus.data_out !== 8'h00) begin
      errors++; $display("FAIL rmid_reset: got usedw=%0d empty=%b dout=%h want 0 1 00",
                         bus.usedw, bus.empty, bus.data_out);
    end
    step(0, '0, 1, 0, 0);
    checks++; if (bus.underflow !== 1'b1 || bus.data_out !== 8'h00) begin
      errors++; $display("FAIL rmid_discard: got unf=%b dout=%h want 1 00", bus.underflow, bus.data_out);
    end
    step(0, '0, 0, 1, 0);
  endtask

  task automatic test_random();
    bit w, r, clr, rst;
    for (int c = 0; c < 600; c++) begin
      if (c < 200)      begin w = ($urandom_range(0, 99) < 70); r = ($urandom_range(0, 99) < 35); end
      else if (c < 400) begin w = ($urandom_range(0, 99) < 35); r = ($urandom_range(0, 99) < 70); end
      else              begin w = $urandom_range(0, 1);          r = $urandom_range(0, 1); end
      clr = ($urandom_range(0, 99) < 5);
      rst = ($urandom_range(0, 999) < 5);
      step(w, 8'($urandom), r, clr, rst);
      checks++;
      if (bus.usedw !== 5'(q.size()) || bus.data_out !== m_dout ||
          bus.empty !== (q.size() == 0) || bus.full !== (q.size() == DEPTH) ||
          bus.almost_full !== (q.size() >= AFULL) ||
          bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
        errors++;
        $display("FAIL random %0d: got usedw=%0d dout=%h e/f/af/o/u=%b%b%b%b%b want %0d %h %b%b%b%b%b",
                 c, bus.usedw, bus.data_out, bus.empty, bus.full, bus.almost_full,
                 bus.overflow, bus.underflow, q.size(), m_dout, (q.size() == 0),
                 (q.size() == DEPTH), (q.size() >= AFULL), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    bus.write = 0; bus.data_wr = '0; bus.read = 0; bus.clear_err = 0; reset = 1;
    m_dout = '0; m_ovf = 0; m_unf = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow_simul();
    test_full_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
